// File: rtl/wallace_operand_packer.sv
// Packs a serial valid/ready stream of W-bit operands into N-slot vectors for the Wallace adder tree.
// Optional feature macro: WALLACE_OPERAND_PACKER_SUM_EN adds a registered out_sum of all slots.
module wallace_operand_packer #(
    parameter int W = 32,
    parameter int N = 4,
    localparam int CW = $clog2(N + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_vld,
    output logic              in_rdy,
    input  logic [W-1:0]      in_data,
    input  logic              in_last,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [W*N-1:0]    out_data,
    output logic [CW-1:0]     out_count
`ifdef WALLACE_OPERAND_PACKER_SUM_EN
    ,
    output logic [W-1:0]      out_sum
`endif
);

    localparam int PW = $clog2(N);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_stateNext;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   w_ptrNext;
    logic [PW-1:0]   w_slot;
    logic [W*N-1:0]  r_buf;
    logic [W*N-1:0]  w_bufNext;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_countNext;
    logic            w_inXfer;
    logic            w_outXfer;

    assign in_rdy    = (r_state == FILL) | out_rdy;
    assign out_vld   = (r_state == FULL);
    assign out_data  = r_buf;
    assign out_count = r_count;
    assign w_inXfer  = in_vld & in_rdy;
    assign w_outXfer = (r_state == FULL) & out_rdy;

    // An operand arriving while FULL can only be taken alongside a drain, so it always starts a fresh vector in slot 0.
    assign w_slot = (r_state == FULL) ? '0 : r_ptr;

    always_comb begin
        w_bufNext   = w_outXfer ? '0 : r_buf;
        w_stateNext = r_state;
        w_ptrNext   = r_ptr;
        w_countNext = r_count;
        if (w_inXfer) begin
            for (int k = 0; k < N; k++) begin
                if (PW'(k) == w_slot) begin
                    w_bufNext[k*W +: W] = in_data;
                end
            end
        end
        case (r_state)
            FILL: begin
                if (w_inXfer) begin
                    if (r_ptr == PW'(N - 1) || in_last) begin
                        w_stateNext = FULL;
                        w_countNext = CW'(r_ptr) + CW'(1);
                        w_ptrNext   = '0;
                    end else begin
                        w_ptrNext = r_ptr + PW'(1);
                    end
                end
            end
            FULL: begin
                if (w_outXfer) begin
                    if (w_inXfer && in_last) begin
                        w_countNext = CW'(1);
                        w_ptrNext   = '0;
                    end else if (w_inXfer) begin
                        w_stateNext = FILL;
                        w_ptrNext   = PW'(1);
                    end else begin
                        w_stateNext = FILL;
                        w_ptrNext   = '0;
                    end
                end
            end
            default: w_stateNext = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FILL;
            r_ptr   <= '0;
            r_buf   <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_stateNext;
            r_ptr   <= w_ptrNext;
            r_buf   <= w_bufNext;
            r_count <= w_countNext;
        end
    end

`ifdef WALLACE_OPERAND_PACKER_SUM_EN
    logic [W-1:0] w_sumNext;
    logic [W-1:0] r_sum;

    // Summing the next-buffer value keeps out_sum aligned with out_data without an extra stage.
    wallace_operand_adder #(.W(W), .N(N)) u_adder (
        .i_operands(w_bufNext),
        .o_sum     (w_sumNext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum <= '0;
        end else begin
            r_sum <= w_sumNext;
        end
    end

    assign out_sum = r_sum;
`endif

endmodule

`ifdef WALLACE_OPERAND_PACKER_SUM_EN
// Combinational multi-operand adder: sum of N W-bit slots, modulo 2^W.
module wallace_operand_adder #(
    parameter int W = 32,
    parameter int N = 4
) (
    input  logic [W*N-1:0] i_operands,
    output logic [W-1:0]   o_sum
);

    logic [W-1:0] w_acc;

    always_comb begin
        w_acc = '0;
        for (int k = 0; k < N; k++) begin
            w_acc = w_acc + i_operands[k*W +: W];
        end
    end

    assign o_sum = w_acc;

endmodule
`endif

// File: tb/tb_wallace_operand_packer.sv
// Directed self-checking bench for wallace_operand_packer with W=8, N=4.
// Define WALLACE_OPERAND_PACKER_SUM_EN to also check out_sum.
module tb_wallace_operand_packer;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int CW = $clog2(N + 1);

    logic              clk;
    logic              rst;
    logic              in_vld;
    logic              in_rdy;
    logic [W-1:0]      in_data;
    logic              in_last;
    logic              out_vld;
    logic              out_rdy;
    logic [W*N-1:0]    out_data;
    logic [CW-1:0]     out_count;
`ifdef WALLACE_OPERAND_PACKER_SUM_EN
    logic [W-1:0]      out_sum;
`endif

    int testsRun;
    int testsFailed;

    wallace_operand_packer #(.W(W), .N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_data (out_data),
        .out_count(out_count)
`ifdef WALLACE_OPERAND_PACKER_SUM_EN
        ,
        .out_sum  (out_sum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic applyStimulus(input logic vld, input logic [W-1:0] data,
                                 input logic last, input logic ordy);
        in_vld  = vld;
        in_data = data;
        in_last = last;
        out_rdy = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        testsRun++;
        if (out_vld !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_out_vld got %b want 0", out_vld);
        end
        testsRun++;
        if (out_data !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL reset_out_data got %h want 00000000", out_data);
        end
        testsRun++;
        if (out_count !== 3'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_out_count got %0d want 0", out_count);
        end
        testsRun++;
        if (in_rdy !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL reset_in_rdy got %b want 1", in_rdy);
        end
`ifdef WALLACE_OPERAND_PACKER_SUM_EN
        testsRun++;
        if (out_sum !== 8'h00) begin
            testsFailed++;
            $display("[TB] FAIL reset_out_sum got %h want 00", out_sum);
        end
`endif
    endtask

    task automatic test_full_vector();
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0, 1'b1);
            #1;
            testsRun++;
            if (in_rdy !== 1'b1) begin
                testsFailed++;
                $display("[TB] FAIL full_in_rdy op%0d got %b want 1", i, in_rdy);
            end
            tick();
            if (i == 3) begin
                testsRun++;
                if (out_vld !== 1'b0) begin
                    testsFailed++;
                    $display("[TB] FAIL full_early_vld got %b want 0", out_vld);
                end
            end
        end
        testsRun++;
        if (out_vld !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL full_out_vld got %b want 1", out_vld);
        end
        testsRun++;
        if (out_data !== 32'h04030201) begin
            testsFailed++;
            $display("[TB] FAIL full_out_data got %h want 04030201", out_data);
        end
        testsRun++;
        if (out_count !== 3'd4) begin
            testsFailed++;
            $display("[TB] FAIL full_out_count got %0d want 4", out_count);
        end
    endtask

    // Follows test_full_vector directly: operand 5 is taken while 0x04030201 drains.
    task automatic test_short_batch();
        applyStimulus(1'b1, 8'h05, 1'b0, 1'b1);
        tick();
        testsRun++;
        if (out_vld !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL short_mid_vld got %b want 0", out_vld);
        end
        applyStimulus(1'b1, 8'h06, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        testsRun++;
        if (out_vld !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL short_out_vld got %b want 1", out_vld);
        end
        testsRun++;
        if (out_data !== 32'h00000605) begin
            testsFailed++;
            $display("[TB] FAIL short_out_data got %h want 00000605", out_data);
        end
        testsRun++;
        if (out_count !== 3'd2) begin
            testsFailed++;
            $display("[TB] FAIL short_out_count got %0d want 2", out_count);
        end
`ifdef WALLACE_OPERAND_PACKER_SUM_EN
        testsRun++;
        if (out_sum !== 8'd11) begin
            testsFailed++;
            $display("[TB] FAIL short_out_sum got %0d want 11", out_sum);
        end
`endif
    endtask

    task automatic test_backpressure();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        tick();
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 8'(i * 8'h11), 1'b0, 1'b1);
            tick();
        end
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
            #1;
            testsRun++;
            if (in_rdy !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL bp_in_rdy cyc%0d got %b want 0", c, in_rdy);
            end
            tick();
            testsRun++;
            if (out_vld !== 1'b1 || out_data !== 32'h44332211 || out_count !== 3'd4) begin
                testsFailed++;
                $display("[TB] FAIL bp_hold cyc%0d got vld=%b data=%h cnt=%0d want vld=1 data=44332211 cnt=4",
                         c, out_vld, out_data, out_count);
            end
        end
        applyStimulus(1'b1, 8'h55, 1'b0, 1'b1);
        #1;
        testsRun++;
        if (in_rdy !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL bp_release_in_rdy got %b want 1", in_rdy);
        end
        tick();
        applyStimulus(1'b1, 8'h66, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        testsRun++;
        if (out_vld !== 1'b1 || out_data !== 32'h00006655 || out_count !== 3'd2) begin
            testsFailed++;
            $display("[TB] FAIL bp_slot0_capture got vld=%b data=%h cnt=%0d want vld=1 data=00006655 cnt=2",
                     out_vld, out_data, out_count);
        end
    endtask

    // Follows test_backpressure: FULL holding 0x00006655.
    task automatic test_single_last();
        applyStimulus(1'b1, 8'hAA, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        testsRun++;
        if (out_vld !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL single_out_vld got %b want 1", out_vld);
        end
        testsRun++;
        if (out_data !== 32'h000000AA) begin
            testsFailed++;
            $display("[TB] FAIL single_out_data got %h want 000000aa", out_data);
        end
        testsRun++;
        if (out_count !== 3'd1) begin
            testsFailed++;
            $display("[TB] FAIL single_out_count got %0d want 1", out_count);
        end
    endtask

    task automatic test_reset_midstream();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 8'h01, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 8'h02, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        testsRun++;
        if (out_vld !== 1'b0 || out_data !== 32'h0 || in_rdy !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL rst_midbatch got vld=%b data=%h rdy=%b want vld=0 data=00000000 rdy=1",
                     out_vld, out_data, in_rdy);
        end
        for (int i = 7; i <= 10; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        testsRun++;
        if (out_vld !== 1'b0 || out_data !== 32'h0 || out_count !== 3'd0 || in_rdy !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL rst_full got vld=%b data=%h cnt=%0d rdy=%b want vld=0 data=00000000 cnt=0 rdy=1",
                     out_vld, out_data, out_count, in_rdy);
        end
        for (int i = 7; i <= 10; i++) begin
            applyStimulus(1'b1, 8'(i), (i == 10) ? 1'b1 : 1'b0, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        testsRun++;
        if (out_vld !== 1'b1 || out_data !== 32'h0A090807 || out_count !== 3'd4) begin
            testsFailed++;
            $display("[TB] FAIL rst_next_batch got vld=%b data=%h cnt=%0d want vld=1 data=0a090807 cnt=4",
                     out_vld, out_data, out_count);
        end
    endtask

`ifdef WALLACE_OPERAND_PACKER_SUM_EN
    task automatic test_sum_wrap();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        testsRun++;
        if (out_vld !== 1'b1 || out_sum !== 8'hFC) begin
            testsFailed++;
            $display("[TB] FAIL sum_wrap got vld=%b sum=%h want vld=1 sum=fc", out_vld, out_sum);
        end
    endtask
`endif

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst         = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        test_reset();
        test_full_vector();
        test_short_batch();
        test_backpressure();
        test_single_last();
        test_reset_midstream();
`ifdef WALLACE_OPERAND_PACKER_SUM_EN
        test_sum_wrap();
`endif
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
